data_memory_responder: RTL and testbench

Responder end of the processor's data-memory interface: accepts one load/store request at a time from the datapath, counts a configurable number of wait states, then completes it with a one-cycle `ready` pulse carrying read data or an error flag. The block sits between the core's `aluout`/`writedata`/`readdata` path and a single-port word RAM. It replaces the zero-latency ideal data memory, so the core can be exercised against realistic memory latency.

---
 rtl/data_memory_responder_pkg.sv | 29 ++
 rtl/data_memory_responder_if.sv | 16 +
 rtl/data_memory_responder_array.sv | 31 +++
 rtl/data_memory_responder.sv | 108 ++++++++++
 tb/tb_data_memory_responder.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared constants, state encoding and address-fault helper for the data-memory responder.
package data_memory_responder_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned ADDR_W1    = ADDR_W + 1;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned CNT_W      = 4;

    localparam logic [ADDR_W-1:0] DMEM_BASE            = 32'h1001_0000;
    localparam int unsigned       DMEM_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } dmr_state_e;

    // Misaligned, below the window, or at/after its end; the limit is formed one bit wider so it cannot wrap.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] base,
                                        input int unsigned       depth_words);
        logic [ADDR_W:0] limit;
        limit = ADDR_W1'(base) + (ADDR_W1'(depth_words) << BYTE_OFF_W);
        return (addr[BYTE_OFF_W-1:0] != '0) || (addr < base) || (ADDR_W1'(addr) >= limit);
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store request and response bus between the datapath (master) and the responder (slave).
interface data_memory_responder_if;
    import data_memory_responder_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              error;

    modport master (output req, we, addr, wdata, input  ready, rdata, error);
    modport slave  (input  req, we, addr, wdata, output ready, rdata, error);

endinterface

// File: rtl/data_memory_responder_array.sv
// Single-port word RAM with write enable and a registered read port; contents are never reset.
module dmem_array
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Write on enable; read data is captured into the port register on read enable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one access at a time, LATENCY wait states, then a one-cycle ready pulse.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE        = DMEM_BASE,
    parameter int unsigned       LATENCY     = DMEM_LATENCY_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    dmr_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic              error_q;

    logic              access_fault;
    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_rdata;

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> BYTE_OFF_W);
    endfunction

    // The read is launched at the accepting edge from the bus address so the word is ready
    // during ACCESS; a faulting address still reads some word, but the result is discarded.
    assign access_fault = addr_fault(addr_q, BASE, DEPTH_WORDS);
    assign ram_re       = (state_q == IDLE) && bus.req && !reset;
    assign ram_we       = (state_q == ACCESS) && we_q && !access_fault && !reset;
    assign ram_idx      = (state_q == IDLE) ? word_index(bus.addr) : word_index(addr_q);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .idx_i   (ram_idx),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Request FSM with wait-state counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    error_q <= access_fault;
                    rdata_q <= (access_fault || we_q) ? '0 : ram_rdata;
                    if (LATENCY == 0) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(LATENCY);
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.error = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (LATENCY 2, 0, 3) against a transaction-level model.
module tb_data_memory_responder;

    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam longint      BASE_L = 64'h1001_0000;
    localparam int          DEPTH  = 1024;

    int lat_tbl [3] = '{2, 0, 3};

    logic clk;
    logic reset;

    logic        req_s   [3];
    logic        we_s    [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic        rdy_w   [3];
    logic [31:0] rd_w    [3];
    logic        err_w   [3];

    int tests = 0;
    int fails = 0;

    data_memory_responder_if bus0 ();
    data_memory_responder_if bus1 ();
    data_memory_responder_if bus2 ();

    assign bus0.req = req_s[0]; assign bus0.we = we_s[0]; assign bus0.addr = addr_s[0]; assign bus0.wdata = wdata_s[0];
    assign bus1.req = req_s[1]; assign bus1.we = we_s[1]; assign bus1.addr = addr_s[1]; assign bus1.wdata = wdata_s[1];
    assign bus2.req = req_s[2]; assign bus2.we = we_s[2]; assign bus2.addr = addr_s[2]; assign bus2.wdata = wdata_s[2];
    assign rdy_w[0] = bus0.ready; assign rd_w[0] = bus0.rdata; assign err_w[0] = bus0.error;
    assign rdy_w[1] = bus1.ready; assign rd_w[1] = bus1.rdata; assign err_w[1] = bus1.error;
    assign rdy_w[2] = bus2.ready; assign rd_w[2] = bus2.rdata; assign err_w[2] = bus2.error;

    data_memory_responder #(.DEPTH_WORDS(1024), .BASE(32'h1001_0000), .LATENCY(2))
        dut_l2 (.clk(clk), .reset(reset), .bus(bus0));
    data_memory_responder #(.DEPTH_WORDS(1024), .BASE(32'h1001_0000), .LATENCY(0))
        dut_l0 (.clk(clk), .reset(reset), .bus(bus1));
    data_memory_responder #(.DEPTH_WORDS(1024), .BASE(32'h1001_0000), .LATENCY(3))
        dut_l3 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] mem_m [3][DEPTH];
    int          cyc = 0;
    bit          model_on = 1'b0;
    bit          busy      [3] = '{0, 0, 0};
    int          acc_c     [3];
    bit          st_we     [3];
    logic [31:0] st_addr   [3];
    logic [31:0] st_wdata  [3];
    logic [31:0] resp_d    [3];
    logic        resp_e    [3];
    logic        exp_ready [3] = '{0, 0, 0};
    logic [31:0] exp_rdata [3];
    logic        exp_error [3];
    bit          chk_all   [3] = '{0, 0, 0};

    // Model step at each rising edge; cyc names the cycle that this edge closes.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            longint a;
            bit     flt;
            int     idx;
            exp_ready[k] = 1'b0;
            chk_all[k]   = 1'b0;
            if (reset) begin
                busy[k]      = 1'b0;
                exp_rdata[k] = 32'h0;
                exp_error[k] = 1'b0;
                chk_all[k]   = 1'b1;
            end else if (busy[k]) begin
                if (cyc == acc_c[k] + 1) begin
                    a   = longint'(st_addr[k]);
                    flt = (a % 4 != 0) || (a < BASE_L) || (a >= BASE_L + 4 * DEPTH);
                    if (flt) begin
                        resp_d[k] = 32'h0;
                        resp_e[k] = 1'b1;
                    end else begin
                        idx = int'((a - BASE_L) / 4);
                        if (st_we[k]) begin
                            mem_m[k][idx] = st_wdata[k];
                            resp_d[k]     = 32'h0;
                        end else begin
                            resp_d[k] = mem_m[k][idx];
                        end
                        resp_e[k] = 1'b0;
                    end
                end
                if (cyc + 1 == acc_c[k] + lat_tbl[k] + 2) begin
                    exp_ready[k] = 1'b1;
                    exp_rdata[k] = resp_d[k];
                    exp_error[k] = resp_e[k];
                end
                if (cyc == acc_c[k] + lat_tbl[k] + 2) busy[k] = 1'b0;
            end else if (req_s[k]) begin
                busy[k]     = 1'b1;
                acc_c[k]    = cyc;
                st_we[k]    = we_s[k];
                st_addr[k]  = addr_s[k];
                st_wdata[k] = wdata_s[k];
            end
        end
        if (reset) model_on = 1'b1;
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every instance against the model, away from the rising edge.
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("dut%0d_ready", k), 32'(rdy_w[k]), 32'(exp_ready[k]));
                if (exp_ready[k]) begin
                    check($sformatf("dut%0d_rdata", k), rd_w[k], exp_rdata[k]);
                    check($sformatf("dut%0d_error", k), 32'(err_w[k]), 32'(exp_error[k]));
                end
                if (chk_all[k]) begin
                    check($sformatf("dut%0d_reset_rdata", k), rd_w[k], 32'h0);
                    check($sformatf("dut%0d_reset_error", k), 32'(err_w[k]), 32'h0);
                end
            end
        end
    end

    // Preload both the DUT array and the model copy of it.
    task preload(input int k, input int i, input logic [31:0] v);
        mem_m[k][i] = v;
        case (k)
            0:       dut_l2.u_array.mem_q[i] <= v;
            1:       dut_l0.u_array.mem_q[i] <= v;
            default: dut_l3.u_array.mem_q[i] <= v;
        endcase
    endtask

    // One access from a negedge; returns data, error and ready cycle relative to acceptance (cycle 0).
    task automatic do_access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                             input int drop_at, output logic [31:0] rd, output logic er, output int rel);
        int c0;
        bit seen;
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
        c0 = cyc; seen = 1'b0; rel = -1; rd = 32'h0; er = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (drop_at != 0 && (cyc - c0) == drop_at) req_s[k] = 1'b0;
            if (rdy_w[k]) begin
                seen = 1'b1; rel = cyc - c0; rd = rd_w[k]; er = err_w[k];
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL dut%0d_timeout: got no ready within 40 cycles, expected ready at %0d", k, lat_tbl[k] + 2);
        end
        req_s[k] = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          rel;
    int          pulses [$];
    int          b2b_exp [3] = '{2, 5, 8};
    int          nrdy;

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
            for (int i = 0; i < DEPTH; i++) preload(k, i, 32'h5A00_0000 ^ (32'(k) << 16) ^ 32'(i));
        end
        preload(0, 0, 32'hDEAD_BEEF);
        preload(0, 5, 32'h0000_0000);
        preload(2, 1, 32'h0BAD_F00D);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Basic load with LATENCY=2.
        do_access(0, 1'b0, BASE, 32'h0, 0, rd, er, rel);
        check("load0_cycle", 32'(rel), 32'd4);
        check("load0_rdata", rd, 32'hDEAD_BEEF);
        check("load0_error", 32'(er), 32'd0);

        // Store to the last word then read it back.
        do_access(0, 1'b1, 32'h1001_0FFC, 32'h1234_5678, 0, rd, er, rel);
        check("store_last_rdata", rd, 32'h0);
        check("store_last_error", 32'(er), 32'd0);
        do_access(0, 1'b0, 32'h1001_0FFC, 32'h0, 0, rd, er, rel);
        check("load_last_rdata", rd, 32'h1234_5678);
        check("load_last_error", 32'(er), 32'd0);

        // Faulting accesses: misaligned, below base, one past the end.
        do_access(0, 1'b0, 32'h1001_0002, 32'h0, 0, rd, er, rel);
        check("fault_misal_error", 32'(er), 32'd1);
        check("fault_misal_rdata", rd, 32'h0);
        do_access(0, 1'b0, 32'h1000_FFFC, 32'h0, 0, rd, er, rel);
        check("fault_below_error", 32'(er), 32'd1);
        check("fault_below_rdata", rd, 32'h0);
        do_access(0, 1'b1, 32'h1001_1000, 32'hCAFE_F00D, 0, rd, er, rel);
        check("fault_above_error", 32'(er), 32'd1);
        check("fault_above_rdata", rd, 32'h0);
        do_access(0, 1'b0, BASE, 32'h0, 0, rd, er, rel);
        check("readback_w0", rd, 32'hDEAD_BEEF);
        do_access(0, 1'b0, 32'h1001_0FFC, 32'h0, 0, rd, er, rel);
        check("readback_last", rd, 32'h1234_5678);

        // Back-to-back requests with LATENCY=0.
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = BASE + 32'd8;
        begin
            int c0;
            c0 = cyc;
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                if (rdy_w[1]) pulses.push_back(cyc - c0);
                if (i == 8) req_s[1] = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_count", 32'(pulses.size()), 32'd3);
        for (int j = 0; j < 3; j++)
            check($sformatf("b2b_pulse%0d", j), (j < pulses.size()) ? 32'(pulses[j]) : 32'hFFFF_FFFF, 32'(b2b_exp[j]));

        // Reset during the ACCESS cycle of a store drops the store.
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = BASE + 32'd20; wdata_s[0] = 32'hAAAA_5555;
        @(negedge clk);
        reset = 1'b1; req_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy_w[0]) nrdy++;
        end
        check("rst_store_no_ready", 32'(nrdy), 32'd0);
        do_access(0, 1'b0, BASE + 32'd20, 32'h0, 0, rd, er, rel);
        check("rst_store_word5", rd, 32'h0);

        // req dropped mid-transaction with LATENCY=3, then a normal follow-up.
        do_access(2, 1'b0, BASE + 32'd4, 32'h0, 2, rd, er, rel);
        check("drop_cycle", 32'(rel), 32'd5);
        check("drop_rdata", rd, 32'h0BAD_F00D);
        do_access(2, 1'b0, BASE + 32'd4, 32'h0, 0, rd, er, rel);
        check("after_drop_cycle", 32'(rel), 32'd5);
        check("after_drop_rdata", rd, 32'h0BAD_F00D);

        // Randomized traffic on all three instances.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30; n++) begin
                int          idx;
                int          kind;
                int          drop;
                logic [31:0] a;
                idx  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
                kind = $urandom_range(0, 9);
                case (kind)
                    0:       a = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
                    1:       a = BASE - 32'($urandom_range(1, 16) * 4);
                    2:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 16) * 4);
                    default: a = BASE + 32'(idx * 4);
                endcase
                drop = ($urandom_range(0, 9) == 0) ? $urandom_range(1, lat_tbl[k] + 1) : 0;
                do_access(k, 1'($urandom_range(0, 1)), a, $urandom, drop, rd, er, rel);
                check($sformatf("rnd_dut%0d_cycle", k), 32'(rel), 32'(lat_tbl[k] + 2));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
